// File: rtl/systolic_pkg.sv
// Shared types for the NxN systolic MAC: controller states and the
// minimum accumulator width that cannot overflow within a single job.
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        COMPUTE = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    function automatic int clog2_min_acc(input int n, input int data_w);
        return 2 * data_w + $clog2(n);
    endfunction

endpackage

// File: rtl/systolic_pe_p.sv
// One output-stationary processing element: it forwards A to the right and B
// downwards, and accumulates their product into a local sum.
module systolic_pe_p #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              en,
    input  logic              signed_mode,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic [ACC_W-1:0]  acc
);

    localparam int PW = 2 * DATA_W + 2;

    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [ACC_W-1:0]  r_acc;

    logic signed [DATA_W:0] w_a_x;
    logic signed [DATA_W:0] w_b_x;
    logic signed [PW-1:0]   w_prod;
    logic [ACC_W-1:0]       w_prod_ext;

    // An extra top bit carries either the sign or a zero, so one signed multiplier serves both modes
    assign w_a_x      = {signed_mode & a_in[DATA_W-1], a_in};
    assign w_b_x      = {signed_mode & b_in[DATA_W-1], b_in};
    assign w_prod     = w_a_x * w_b_x;
    assign w_prod_ext = ACC_W'(w_prod);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
        end else if (en) begin
            r_a   <= a_in;
            r_b   <= b_in;
            r_acc <= clr ? w_prod_ext : r_acc + w_prod_ext;
        end
    end

    assign a_out = r_a;
    assign b_out = r_b;
    assign acc   = r_acc;

endmodule

// File: rtl/systolic_mac_nxn.sv
// NxN output-stationary systolic multiplier C = A x B (or C += A x B) with
// valid/ready operand and result streams.
//   state   | meaning
//   IDLE    | waiting for A row 0; job modes are latched with it
//   LOAD    | taking A rows 1..N-1, then B columns 0..N-1
//   COMPUTE | 3N-1 cycles of skewed injection, the last one a flush
//   DRAIN   | presenting C one row per handshake
module systolic_mac_nxn
    import systolic_pkg::*;
#(
    parameter int N      = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N*DATA_W-1:0] in_data,
    input  logic                signed_mode,
    input  logic                acc_mode,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N*ACC_W-1:0]  out_data,
    output logic                out_last,
    output logic                busy,
    output logic                done
);

    if (ACC_W < clog2_min_acc(N, DATA_W)) begin : g_acc_w_check
        $error("systolic_mac_nxn: ACC_W too small for N and DATA_W");
    end

    localparam int BW = $clog2(2 * N);
    localparam int TW = $clog2(3 * N);
    localparam int RW = (N > 1) ? $clog2(N) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(2 * N - 1);
    localparam logic [TW-1:0] LAST_T    = TW'(3 * N - 2);
    localparam logic [RW-1:0] LAST_ROW  = RW'(N - 1);

    state_t          r_state, w_state_nxt;
    logic [BW-1:0]   r_beat;
    logic [TW-1:0]   r_t;
    logic [RW-1:0]   r_row;
    logic            r_signed, r_acc_mode, r_done;

    logic [DATA_W-1:0] r_a [N][N];
    logic [DATA_W-1:0] r_b [N][N];

    logic [DATA_W-1:0] w_inj_a [N];
    logic [DATA_W-1:0] w_inj_b [N];
    logic [DATA_W-1:0] w_a_bus [N][N+1];
    logic [DATA_W-1:0] w_b_bus [N+1][N];
    logic [ACC_W-1:0]  w_acc   [N][N];

    logic w_in_fire, w_out_fire, w_pe_en, w_pe_clr, w_last_out;

    assign in_ready   = (r_state == IDLE) || (r_state == LOAD);
    assign out_valid  = (r_state == DRAIN);
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;
    assign w_last_out = w_out_fire && (r_row == LAST_ROW);
    assign out_last   = out_valid && (r_row == LAST_ROW);
    assign busy       = (r_state != IDLE);
    assign done       = r_done;
    assign w_pe_en    = (r_state == COMPUTE);
    assign w_pe_clr   = w_pe_en && (r_t == '0) && !r_acc_mode;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_in_fire) w_state_nxt = LOAD;
            LOAD:    if (w_in_fire && r_beat == LAST_BEAT) w_state_nxt = COMPUTE;
            COMPUTE: if (r_t == LAST_T) w_state_nxt = DRAIN;
            DRAIN:   if (w_last_out) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_beat     <= '0;
            r_t        <= '0;
            r_row      <= '0;
            r_signed   <= 1'b0;
            r_acc_mode <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_last_out;
            if (w_in_fire) begin
                if (r_state == IDLE) begin
                    r_signed   <= signed_mode;
                    r_acc_mode <= acc_mode;
                end
                r_beat <= (r_beat == LAST_BEAT) ? '0 : r_beat + 1'b1;
            end
            if (r_state == COMPUTE) r_t <= (r_t == LAST_T) ? '0 : r_t + 1'b1;
            if (w_out_fire) r_row <= (r_row == LAST_ROW) ? '0 : r_row + 1'b1;
        end
    end

    // Beat b < N is A row b; beat N+j is B column j (element k is B[k][j])
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                for (int k = 0; k < N; k++) begin
                    r_a[i][k] <= '0;
                    r_b[i][k] <= '0;
                end
            end
        end else if (w_in_fire) begin
            for (int i = 0; i < N; i++) begin
                for (int k = 0; k < N; k++) begin
                    if (int'(r_beat) == i)     r_a[i][k] <= in_data[k*DATA_W +: DATA_W];
                    if (int'(r_beat) == N + i) r_b[k][i] <= in_data[k*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Row i sees A[i][t-i], column j sees B[t-j][j]; zero outside the matrix
    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_inj_a[i] = '0;
            w_inj_b[i] = '0;
            for (int k = 0; k < N; k++) begin
                if (int'(r_t) == i + k) begin
                    w_inj_a[i] = r_a[i][k];
                    w_inj_b[i] = r_b[k][i];
                end
            end
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_edge
        assign w_a_bus[i][0] = w_inj_a[i];
        assign w_b_bus[0][i] = w_inj_b[i];
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            systolic_pe_p #(
                .DATA_W (DATA_W),
                .ACC_W  (ACC_W)
            ) u_pe (
                .clk         (clk),
                .reset       (reset),
                .clr         (w_pe_clr),
                .en          (w_pe_en),
                .signed_mode (r_signed),
                .a_in        (w_a_bus[i][j]),
                .b_in        (w_b_bus[i][j]),
                .a_out       (w_a_bus[i][j+1]),
                .b_out       (w_b_bus[i+1][j]),
                .acc         (w_acc[i][j])
            );
        end
    end

    always_comb begin
        out_data = '0;
        if (r_state == DRAIN) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    if (int'(r_row) == i) out_data[j*ACC_W +: ACC_W] = w_acc[i][j];
                end
            end
        end
    end

endmodule

// File: tb/tb_systolic_mac_nxn.sv
// Randomised bench for systolic_mac_nxn (4x4x8 plus a 1x1x4 instance) against
// a plain matrix-arithmetic reference model.
module tb_systolic_mac_nxn;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int AW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset;
    logic            in_valid, in_ready, signed_mode, acc_mode;
    logic [N*DW-1:0] in_data;
    logic            out_valid, out_ready, out_last, busy, done;
    logic [N*AW-1:0] out_data;

    logic       in_valid1, in_ready1, signed_mode1, acc_mode1;
    logic [3:0] in_data1;
    logic       out_valid1, out_ready1, out_last1, busy1, done1;
    logic [7:0] out_data1;

    systolic_mac_nxn #(.N(N), .DATA_W(DW), .ACC_W(AW)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .signed_mode(signed_mode), .acc_mode(acc_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .done(done)
    );

    systolic_mac_nxn #(.N(1), .DATA_W(4), .ACC_W(8)) u_dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_data(in_data1), .signed_mode(signed_mode1), .acc_mode(acc_mode1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
        .out_last(out_last1), .busy(busy1), .done(done1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int          ma [N][N];
    int          mb [N][N];
    logic [31:0] mc [N][N];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic longint elem(input int x, input bit sm);
        return (sm && x >= 128) ? longint'(x) - 256 : longint'(x);
    endfunction

    // C = (acc ? C : 0) + A*B, wrapped to 32 bits
    task automatic model_job(input bit sm, input bit am);
        logic [31:0] sum;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                sum = am ? mc[i][j] : 32'd0;
                for (int k = 0; k < N; k++) sum += 32'(elem(ma[i][k], sm) * elem(mb[k][j], sm));
                mc[i][j] = sum;
            end
        end
    endtask

    function automatic logic [N*DW-1:0] beat_data(input int b);
        logic [N*DW-1:0] d;
        for (int k = 0; k < N; k++) d[k*DW +: DW] = (b < N) ? 8'(ma[b][k]) : 8'(mb[k][b-N]);
        return d;
    endfunction

    function automatic logic [N*AW-1:0] row_exp(input int r);
        logic [N*AW-1:0] d;
        for (int j = 0; j < N; j++) d[j*AW +: AW] = mc[r][j];
        return d;
    endfunction

    // Returns at the negedge of the cycle in which the last beat handshakes
    task automatic send_beats(input bit sm, input bit am, input bit gaps);
        int beat = 0;
        int budget = 0;
        while (beat < 2 * N && budget < 200) begin
            @(negedge clk);
            budget++;
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                in_data  = N*DW'($urandom);
            end else begin
                in_valid    = 1'b1;
                in_data     = beat_data(beat);
                signed_mode = sm;
                acc_mode    = am;
                if (in_ready) beat++;
            end
        end
        if (beat < 2 * N) check("load_timeout", 128'(beat), 128'(2 * N));
    endtask

    task automatic collect(input int stall_row);
        int cnt = 0;
        do begin
            @(negedge clk);
            in_valid    = 1'b0;
            signed_mode = $urandom_range(0, 1);
            acc_mode    = $urandom_range(0, 1);
            cnt++;
            if (cnt == 1) check("in_ready_compute", 128'(in_ready), 128'(0));
        end while (!out_valid && cnt < 100);
        check("latency", 128'(cnt), 128'(3 * N));
        for (int r = 0; r < N; r++) begin
            if (r == stall_row) begin
                out_ready = 1'b0;
                repeat (5) begin
                    check("stall_data", out_data, row_exp(r));
                    check("stall_last", 128'(out_last), 128'(r == N - 1));
                    @(negedge clk);
                end
            end else if ($urandom_range(0, 2) == 0) begin
                out_ready = 1'b0;
                @(negedge clk);
            end
            out_ready = 1'b1;
            check("out_valid", 128'(out_valid), 128'(1));
            check("row_data", out_data, row_exp(r));
            check("out_last", 128'(out_last), 128'(r == N - 1));
            @(negedge clk);
        end
        out_ready = 1'b0;
        check("done_pulse", 128'(done), 128'(1));
        check("idle_busy", 128'(busy), 128'(0));
        check("idle_out_valid", 128'(out_valid), 128'(0));
        @(negedge clk);
        check("done_single", 128'(done), 128'(0));
    endtask

    task automatic run_job(input bit sm, input bit am, input bit gaps, input int stall_row);
        model_job(sm, am);
        send_beats(sm, am, gaps);
        collect(stall_row);
    endtask

    task automatic fill_const(input int a, input int b);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ma[i][j] = a;
                mb[i][j] = b;
            end
    endtask

    task automatic fill_random();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ma[i][j] = int'($urandom_range(0, 255));
                mb[i][j] = int'($urandom_range(0, 255));
            end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, 128'(in_ready), 128'(1));
        check({tag, "_out_valid"}, 128'(out_valid), 128'(0));
        check({tag, "_out_data"}, out_data, 128'(0));
        check({tag, "_out_last"}, 128'(out_last), 128'(0));
        check({tag, "_busy"}, 128'(busy), 128'(0));
        check({tag, "_done"}, 128'(done), 128'(0));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        reset = 1'b1;
        in_valid = 1'b0; in_data = '0; signed_mode = 1'b0; acc_mode = 1'b0; out_ready = 1'b0;
        in_valid1 = 1'b0; in_data1 = '0; signed_mode1 = 1'b0; acc_mode1 = 1'b0; out_ready1 = 1'b0;
        for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) mc[i][j] = '0;
        repeat (3) @(negedge clk);
        check_reset_values("rst");
        reset = 1'b0;
        @(negedge clk);
        check_reset_values("post_rst");

        // Identity times B[i][j] = 4i+j, signed
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ma[i][j] = (i == j) ? 1 : 0;
                mb[i][j] = 4 * i + j;
            end
        run_job(1'b1, 1'b0, 1'b0, -1);

        fill_const(8'h80, 8'h80);
        run_job(1'b1, 1'b0, 1'b0, -1);
        run_job(1'b0, 1'b0, 1'b1, 2);

        fill_const(8'hFF, 8'hFF);
        run_job(1'b0, 1'b0, 1'b0, -1);
        run_job(1'b0, 1'b1, 1'b1, 2);
        check("ff_acc_value", 128'(mc[3][3]), 128'(520200));

        for (int n = 0; n < 6; n++) begin
            fill_random();
            run_job(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1,
                    int'($urandom_range(0, N)));
        end

        // Abort during COMPUTE t=5, then accumulate onto what must be zero
        fill_random();
        send_beats(1'b1, 1'b0, 1'b1);
        repeat (6) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        check("abort_busy_before", 128'(busy), 128'(1));
        reset = 1'b1;
        #1;
        check_reset_values("abort");
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) mc[i][j] = '0;
        fill_random();
        run_job(1'b1, 1'b1, 1'b1, -1);

        // 1x1, 4-bit signed: -3 * 5
        @(negedge clk);
        in_valid1 = 1'b1; in_data1 = 4'hD; signed_mode1 = 1'b1; acc_mode1 = 1'b0;
        check("n1_ready_idle", 128'(in_ready1), 128'(1));
        @(negedge clk);
        in_data1 = 4'h5;
        check("n1_ready_load", 128'(in_ready1), 128'(1));
        cnt = 0;
        do begin
            @(negedge clk);
            in_valid1 = 1'b0;
            cnt++;
        end while (!out_valid1 && cnt < 20);
        check("n1_latency", 128'(cnt), 128'(3));
        check("n1_data", 128'(out_data1), 128'(8'hF1));
        check("n1_last", 128'(out_last1), 128'(1));
        out_ready1 = 1'b1;
        @(negedge clk);
        out_ready1 = 1'b0;
        check("n1_done", 128'(done1), 128'(1));
        check("n1_busy", 128'(busy1), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
